// File: rtl/dac80504_spi_responder.sv
// DAC80504 SPI responder: oversampled SPI frame decoder, register file and four DAC channels with LDAC semantics.
// Build option DAC_READBACK_EN adds the read-frame readback shifter on sdo_o; without it sdo_o is tied low.
module dac80504_spi_responder #(
    parameter logic [15:0] DEVICE_ID   = 16'h0294,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk_i,
    input  logic        csn_i,
    input  logic        sdi_i,
    input  logic        ldacn_i,
    output logic        sdo_o,
    output logic [15:0] dac0_o,
    output logic [15:0] dac1_o,
    output logic [15:0] dac2_o,
    output logic [15:0] dac3_o,
    output logic [3:0]  dac_upd_o,
    output logic        frm_err_o
);

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned NSYNC   = (SYNC_STAGES < 32'd2) ? 32'd2 : SYNC_STAGES;

    typedef struct packed {
        logic              rw;
        logic [2:0]        rsvd;
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    logic [NSYNC-1:0]   sclk_sync, csn_sync, sdi_sync, ldacn_sync;
    logic               sclk_cur, sclk_prev, csn_cur, csn_prev, ldacn_cur, ldacn_prev, sdi_cur;
    logic               sclk_rise, sclk_fall, csn_rise, csn_fall, ldac_fall;
    logic               csn_fall_hold;

    state_t             state, state_nxt;
    logic               start_c, shift_c, decode_c;

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    frame_t             frame;
    logic               frame_ok, wr_en, soft_rst, soft_ldac, ldac_evt, status_clr;

    logic [3:0]         sync_q;
    logic [DATA_W-1:0]  config_q, gain_q;
    logic [DATA_W-1:0]  buf_q   [NUM_CH];
    logic [DATA_W-1:0]  act_q   [NUM_CH];
    logic [DATA_W-1:0]  act_nxt [NUM_CH];

    // Input synchronisers followed by one cur/prev stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync  <= '0;
            csn_sync   <= '0;
            sdi_sync   <= '0;
            ldacn_sync <= '0;
            sclk_cur   <= 1'b0;
            csn_cur    <= 1'b0;
            sdi_cur    <= 1'b0;
            ldacn_cur  <= 1'b0;
            sclk_prev  <= 1'b0;
            csn_prev   <= 1'b0;
            ldacn_prev <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[NSYNC-2:0], sclk_i};
            csn_sync   <= {csn_sync[NSYNC-2:0], csn_i};
            sdi_sync   <= {sdi_sync[NSYNC-2:0], sdi_i};
            ldacn_sync <= {ldacn_sync[NSYNC-2:0], ldacn_i};
            sclk_cur   <= sclk_sync[NSYNC-1];
            csn_cur    <= csn_sync[NSYNC-1];
            sdi_cur    <= sdi_sync[NSYNC-1];
            ldacn_cur  <= ldacn_sync[NSYNC-1];
            sclk_prev  <= sclk_cur;
            csn_prev   <= csn_cur;
            ldacn_prev <= ldacn_cur;
        end
    end

    assign sclk_rise = sclk_cur & ~sclk_prev;
    assign sclk_fall = ~sclk_cur & sclk_prev;
    assign csn_rise  = csn_cur & ~csn_prev;
    assign csn_fall  = ~csn_cur & csn_prev;
    assign ldac_fall = ~ldacn_cur & ldacn_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            csn_fall_hold <= 1'b0;
        end else begin
            state         <= state_nxt;
            csn_fall_hold <= decode_c & csn_fall;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (csn_fall || csn_fall_hold) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (csn_rise) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_c  = 1'b0;
        shift_c  = 1'b0;
        decode_c = 1'b0;
        case (state)
            ST_IDLE:   start_c  = csn_fall | csn_fall_hold;
            ST_SHIFT:  shift_c  = 1'b1;
            ST_DECODE: decode_c = 1'b1;
            default:   ;
        endcase
    end

    // Frame shifter: sample SDI on SCLK falling edges, MSB first, count saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (start_c) begin
            bit_cnt <= '0;
        end else if (shift_c && sclk_fall) begin
            shreg <= {shreg[FRAME_W-2:0], sdi_cur};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign frame     = frame_t'(shreg);
    assign frame_ok  = decode_c && (bit_cnt == CNT_W'(FRAME_W));
    assign wr_en     = frame_ok && !frame.rw;
    assign soft_rst  = wr_en && (frame.addr == 4'h5) && (frame.data[3:0] == 4'b1010);
    assign soft_ldac = wr_en && (frame.addr == 4'h5) && frame.data[4] && !soft_rst;
    assign ldac_evt  = ldac_fall | soft_ldac;

    // LDAC copies the pre-write buffer; an unbuffered write lands directly in the active code
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            act_nxt[ch] = act_q[ch];
            if (ldac_evt && sync_q[ch]) act_nxt[ch] = buf_q[ch];
            if (wr_en && (frame.addr == 4'(ch + 32'd8)) && !sync_q[ch]) act_nxt[ch] = frame.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            config_q  <= '0;
            gain_q    <= '0;
            dac_upd_o <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                buf_q[ch] <= '0;
                act_q[ch] <= '0;
            end
        end else if (soft_rst) begin
            sync_q    <= '0;
            config_q  <= '0;
            gain_q    <= '0;
            dac_upd_o <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                buf_q[ch] <= '0;
                act_q[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                act_q[ch]     <= act_nxt[ch];
                dac_upd_o[ch] <= (act_nxt[ch] != act_q[ch]);
            end
            if (wr_en) begin
                case (frame.addr)
                    4'h2:                   sync_q   <= frame.data[3:0];
                    4'h3:                   config_q <= frame.data;
                    4'h4:                   gain_q   <= frame.data;
                    4'h8, 4'h9, 4'hA, 4'hB: buf_q[frame.addr[1:0]] <= frame.data;
                    default:                ;
                endcase
            end
        end
    end

    // Sticky length error; soft reset deliberately leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_err_o <= 1'b0;
        end else if (decode_c && !frame_ok) begin
            frm_err_o <= 1'b1;
        end else if (status_clr) begin
            frm_err_o <= 1'b0;
        end
    end

    assign dac0_o = act_q[0];
    assign dac1_o = act_q[1];
    assign dac2_o = act_q[2];
    assign dac3_o = act_q[3];

`ifdef DAC_READBACK_EN
    logic [FRAME_W-1:0] rb_pend, rb_sh;
    logic [DATA_W-1:0]  rd_data;
    logic               unused_bits;

    always_comb begin
        rd_data = '0;
        case (frame.addr)
            4'h1:                   rd_data = DEVICE_ID;
            4'h7:                   rd_data = DATA_W'(frm_err_o);
            4'h8, 4'h9, 4'hA, 4'hB: rd_data = buf_q[frame.addr[1:0]];
            default:                ;
        endcase
    end

    assign status_clr = frame_ok && frame.rw && (frame.addr == 4'h7);

    // Read result is staged until the next frame starts, then shifted out on SCLK rising edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_pend <= '0;
            rb_sh   <= '0;
        end else begin
            if (soft_rst)      rb_pend <= '0;
            else if (decode_c) rb_pend <= (frame_ok && frame.rw) ? {4'h8, frame.addr, rd_data} : '0;

            if (soft_rst)                  rb_sh <= '0;
            else if (start_c)              rb_sh <= rb_pend;
            else if (shift_c && sclk_rise) rb_sh <= {rb_sh[FRAME_W-2:0], 1'b0};
        end
    end

    assign sdo_o       = rb_sh[FRAME_W-1];
    assign unused_bits = ^{frame.rsvd, config_q, gain_q};
`else
    logic unused_bits;

    assign status_clr  = 1'b0;
    assign sdo_o       = 1'b0;
    assign unused_bits = ^{frame.rsvd, config_q, gain_q, DEVICE_ID, sclk_rise};
`endif

endmodule

// File: tb/tb_dac80504_spi_responder.sv
// Bench for dac80504_spi_responder: directed scenarios plus randomized frames checked against a register-level model.
`timescale 1ns/1ps
module tb_dac80504_spi_responder;

    logic        clk = 1'b0;
    logic        rst, sclk_i, csn_i, sdi_i, ldacn_i;
    logic        sdo_o, frm_err_o;
    logic [15:0] dac0_o, dac1_o, dac2_o, dac3_o;
    logic [3:0]  dac_upd_o;

    dac80504_spi_responder #(.DEVICE_ID(16'h0294), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk_i(sclk_i), .csn_i(csn_i), .sdi_i(sdi_i), .ldacn_i(ldacn_i),
        .sdo_o(sdo_o), .dac0_o(dac0_o), .dac1_o(dac1_o), .dac2_o(dac2_o), .dac3_o(dac3_o),
        .dac_upd_o(dac_upd_o), .frm_err_o(frm_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: device registers as plain variables
    logic [3:0]  m_sync;
    logic [15:0] m_buf [4];
    logic [15:0] m_act [4];
    logic        m_err;
    logic [23:0] m_rb;
    logic        m_quiet;
    logic [15:0] act_before [4];
    logic [3:0]  upd_seen;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_sync = '0;
        m_rb   = '0;
        for (int i = 0; i < 4; i++) begin
            m_buf[i] = '0;
            m_act[i] = '0;
        end
    endtask

    task automatic m_ldac();
        for (int i = 0; i < 4; i++)
            if (m_sync[i]) m_act[i] = m_buf[i];
    endtask

    function automatic logic [15:0] m_reg(input logic [3:0] a);
        if (a == 4'h1) return 16'h0294;
        if (a == 4'h7) return {15'b0, m_err};
        if (a >= 4'h8 && a <= 4'hB) return m_buf[int'(a) - 8];
        return 16'h0000;
    endfunction

    task automatic m_frame(input logic [23:0] w, input int nbits);
        logic [3:0]  a;
        logic [15:0] d;
        int          ch;
        a = w[19:16];
        d = w[15:0];
        if (nbits != 24) begin
            m_err = 1'b1;
            m_rb  = '0;
            return;
        end
        if (w[23]) begin
`ifdef DAC_READBACK_EN
            m_rb = {4'h8, a, m_reg(a)};
            if (a == 4'h7) m_err = 1'b0;
`endif
            return;
        end
        m_rb = '0;
        if (a == 4'h2) m_sync = d[3:0];
        if (a == 4'h5) begin
            if (d[3:0] == 4'b1010) begin
                m_clear();
                m_quiet = 1'b1;
            end else if (d[4]) begin
                m_ldac();
            end
        end
        if (a >= 4'h8 && a <= 4'hB) begin
            ch = int'(a) - 8;
            m_buf[ch] = d;
            if (!m_sync[ch]) m_act[ch] = d;
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) act_before[i] = m_act[i];
        upd_seen = '0;
        m_quiet  = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            upd_seen = upd_seen | dac_upd_o;
        end
    endtask

    task automatic check_state(input string tag, input bit with_upd);
        logic [3:0] e;
        check({tag, "_dac0"}, 32'(dac0_o), 32'(m_act[0]));
        check({tag, "_dac1"}, 32'(dac1_o), 32'(m_act[1]));
        check({tag, "_dac2"}, 32'(dac2_o), 32'(m_act[2]));
        check({tag, "_dac3"}, 32'(dac3_o), 32'(m_act[3]));
        check({tag, "_err"},  32'(frm_err_o), 32'(m_err));
        if (with_upd) begin
            for (int i = 0; i < 4; i++) e[i] = (m_act[i] != act_before[i]) && !m_quiet;
            check({tag, "_upd"}, 32'(upd_seen), 32'(e));
        end
    endtask

    // Master side of one SPI frame; sdo is read just before each SCLK rising edge
    task automatic send(input logic [23:0] w, input int nbits, input bit raise, output logic [23:0] rd);
        logic [23:0] sh;
        sh = w;
        rd = '0;
        csn_i = 1'b0;
        cyc(6);
        for (int i = 0; i < nbits; i++) begin
            if (i < 24) rd = {rd[22:0], sdo_o};
            sdi_i = sh[23];
            sh    = {sh[22:0], 1'b0};
            sclk_i = 1'b1;
            cyc(3);
            sclk_i = 1'b0;
            cyc(3);
        end
        cyc(2);
        if (raise) csn_i = 1'b1;
    endtask

    task automatic post(input string tag, input logic [23:0] w, input int nbits, input logic [23:0] rd);
        if (nbits == 24) check({tag, "_sdo"}, 32'(rd), 32'(m_rb));
        snap();
        m_frame(w, nbits);
        settle(12);
        check_state(tag, 1'b1);
    endtask

    task automatic frame(input string tag, input logic [23:0] w, input int nbits);
        logic [23:0] rd;
        send(w, nbits, 1'b1, rd);
        post(tag, w, nbits, rd);
    endtask

    task automatic hw_ldac(input string tag);
        snap();
        ldacn_i = 1'b0;
        settle(8);
        ldacn_i = 1'b1;
        settle(4);
        m_ldac();
        check_state(tag, 1'b1);
    endtask

    logic [3:0]  addr_tab [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};

    initial begin
        logic [23:0] rd;
        logic [23:0] w;
        int          n;

        rst = 1'b1; sclk_i = 1'b0; csn_i = 1'b1; sdi_i = 1'b0; ldacn_i = 1'b1;
        m_clear();
        m_err = 1'b0;
        m_quiet = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(4);

        check("rst_dac0", 32'(dac0_o), 0);
        check("rst_dac3", 32'(dac3_o), 0);
        check("rst_upd",  32'(dac_upd_o), 0);
        check("rst_sdo",  32'(sdo_o), 0);
        check("rst_err",  32'(frm_err_o), 0);

        // Unbuffered write: active code lands 5 clocks after CSN rises, one-clock update pulse
        send(24'h080001, 24, 1'b1, rd);
        cyc(4);
        check("wr0_early_dac", 32'(dac0_o), 0);
        check("wr0_early_upd", 32'(dac_upd_o), 0);
        cyc(1);
        check("wr0_dac", 32'(dac0_o), 32'h0001);
        check("wr0_upd", 32'(dac_upd_o), 32'b0001);
        cyc(1);
        check("wr0_upd_end", 32'(dac_upd_o), 0);
        snap();
        m_frame(24'h080001, 24);
        cyc(6);
        check_state("wr0", 1'b0);

        // Buffered write waits for hardware LDAC
        frame("sync_f", 24'h02000F, 24);
        frame("buf1", 24'h091234, 24);
        check("buf1_hold", 32'(dac1_o), 0);
        hw_ldac("hwldac");
        check("hwldac_dac1", 32'(dac1_o), 32'h1234);

        // Short frame sets the sticky error and changes nothing
        frame("short20", 24'h0A5555, 20);
        check("short20_err", 32'(frm_err_o), 1);

        // STATUS read: error held until that read decodes
        send(24'h870000, 24, 1'b1, rd);
        cyc(3);
        check("status_hold", 32'(frm_err_o), 1);
        post("status_rd", 24'h870000, 24, rd);
        frame("id_rd", 24'h810000, 24);
        send(24'h000000, 24, 1'b1, rd);
`ifdef DAC_READBACK_EN
        check("id_readback", 32'(rd), 32'h810294);
`else
        check("no_readback", 32'(rd), 0);
`endif
        post("noop", 24'h000000, 24, rd);

        // Soft LDAC moves all buffered channels in the same clock
        frame("b0", 24'h080001, 24);
        frame("b1", 24'h090002, 24);
        frame("b2", 24'h0A0003, 24);
        frame("b3", 24'h0B0004, 24);
        send(24'h050010, 24, 1'b1, rd);
        cyc(4);
        check("sldac_early_dac1", 32'(dac1_o), 32'h1234);
        check("sldac_early_dac2", 32'(dac2_o), 0);
        cyc(1);
        check("sldac_dac0", 32'(dac0_o), 32'h0001);
        check("sldac_dac1", 32'(dac1_o), 32'h0002);
        check("sldac_dac2", 32'(dac2_o), 32'h0003);
        check("sldac_dac3", 32'(dac3_o), 32'h0004);
        check("sldac_upd",  32'(dac_upd_o), 32'b1110);
        snap();
        m_frame(24'h050010, 24);
        cyc(6);
        check_state("sldac", 1'b0);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            n = int'($urandom_range(0, 9));
            if (n == 0) begin
                hw_ldac("rnd_ldac");
            end else if (n == 1) begin
                n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 23)) : int'($urandom_range(25, 34));
                frame("rnd_short", 24'($urandom), n);
            end else begin
                w = {($urandom_range(0, 3) == 0), 3'($urandom), addr_tab[$urandom_range(0, 10)], 16'($urandom)};
                frame("rnd", w, 24);
            end
        end

        // Reset in the middle of a frame, then a clean frame
        send(24'h0A1111, 12, 1'b0, rd);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("mrst_dac0", 32'(dac0_o), 0);
        check("mrst_dac3", 32'(dac3_o), 0);
        check("mrst_upd",  32'(dac_upd_o), 0);
        check("mrst_sdo",  32'(sdo_o), 0);
        check("mrst_err",  32'(frm_err_o), 0);
        csn_i = 1'b1;
        cyc(6);
        m_clear();
        m_err = 1'b0;
        frame("beef", 24'h0BBEEF, 24);
        check("beef_dac3", 32'(dac3_o), 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
